// File: rtl/l2_bank_pkg.sv
// l2_bank_pkg: shared types and constants for the L2 bank controller.
//   state_e  : controller FSM states (zero-fill, normal run)
//   rsp_e    : source selector for the registered response data
//   ERR_DATA : read data returned for out-of-range accesses
//   ADDR_W / DATA_W / BE_W : TCDM bus widths
package l2_bank_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [DATA_W-1:0] ERR_DATA = 32'hBADA_CCE5;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  typedef enum logic [1:0] {
    RSP_ZERO,
    RSP_MEM,
    RSP_ERR
  } rsp_e;

  // Byte-offset window test; the subtraction wraps, so addresses below the
  // base land far above the window and are rejected as well.
  function automatic logic addr_in_range(
    input logic [ADDR_W-1:0] offset,
    input logic [ADDR_W-1:0] bytes
  );
    return offset < bytes;
  endfunction

endpackage

// File: rtl/l2_bank_ctrl_if.sv
// l2_bank_ctrl_if: TCDM request/response bus between the lint master and
// the L2 bank controller.
//   req, add, wen (1 = read), wdata, be : request, driven by the master
//   gnt                                : same-cycle grant, driven by the bank
//   r_valid, r_rdata                   : response one cycle after the grant
interface l2_bank_ctrl_if;

  logic                            req;
  logic [l2_bank_pkg::ADDR_W-1:0]  add;
  logic                            wen;
  logic [l2_bank_pkg::DATA_W-1:0]  wdata;
  logic [l2_bank_pkg::BE_W-1:0]    be;
  logic                            gnt;
  logic                            r_valid;
  logic [l2_bank_pkg::DATA_W-1:0]  r_rdata;

  modport master (
    output req, add, wen, wdata, be,
    input  gnt, r_valid, r_rdata
  );

  modport slave (
    input  req, add, wen, wdata, be,
    output gnt, r_valid, r_rdata
  );

endinterface

// File: rtl/l2_bank_init_seq.sv
// l2_bank_init_seq: zero-fill word counter and init request edge detector.
//   clk, rst_n  : clock, asynchronous active-low reset
//   init_n      : raw init request; a high-to-low transition is reported
//   fill_en     : advance the counter (controller is filling)
//   fill_clr    : restart the counter at word 0
//   cnt         : word address of the current fill write
//   done        : final fill word is being written this cycle
//   init_fall   : init_n was high last cycle and is low now
module l2_bank_init_seq #(
  parameter  int unsigned NUM_WORDS = 8192,
  localparam int unsigned AW        = $clog2(NUM_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_n,
  input  logic          fill_en,
  input  logic          fill_clr,
  output logic [AW-1:0] cnt,
  output logic          done,
  output logic          init_fall
);

  logic init_prev;

  // init_prev resets low so a line already low at reset release is not
  // mistaken for a fresh request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      init_prev <= 1'b0;
    end else begin
      init_prev <= init_n;
      if (fill_clr) begin
        cnt <= '0;
      end else if (fill_en) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // The counter wraps to zero on its own after the last word.
  assign done      = fill_en && (cnt == AW'(NUM_WORDS - 1));
  assign init_fall = init_prev && !init_n;

endmodule

// File: rtl/l2_bank_ctrl.sv
// l2_bank_ctrl: single-bank L2 controller, TCDM bus to one SRAM macro.
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   init_ni          : falling edge requests a zero-fill of the bank
//   tcdm             : TCDM slave port (req/gnt, 1-cycle r_valid response)
//   mem_csn_o/wen_o  : SRAM chip select / write enable, active-low
//   mem_addr_o       : SRAM word address
//   mem_wdata_o/be_o : SRAM write data / byte enables
//   mem_rdata_i      : SRAM read data, one cycle after a read select
//   busy_o           : zero-fill in progress
//   err_o, err_clr_i : sticky out-of-range flag and its clear
// Optional macro L2_BANK_ACC_CNT_EN adds rd_cnt_o / wr_cnt_o, saturating
// counts of in-range granted reads and writes, cleared by err_clr_i.
module l2_bank_ctrl
  import l2_bank_pkg::*;
#(
  parameter  int unsigned       NUM_WORDS     = 8192,
  parameter  logic [ADDR_W-1:0] BASE_ADDR     = 32'h1C00_0000,
  parameter  bit                INIT_ON_RESET = 1'b1,
  localparam int unsigned       MEM_AW        = $clog2(NUM_WORDS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              init_ni,
  l2_bank_ctrl_if.slave     tcdm,
  output logic              mem_csn_o,
  output logic              mem_wen_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [BE_W-1:0]   mem_be_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              busy_o,
  output logic              err_o,
  input  logic              err_clr_i
`ifdef L2_BANK_ACC_CNT_EN
  ,
  output logic [31:0]       rd_cnt_o,
  output logic [31:0]       wr_cnt_o
`endif
);

  localparam logic [ADDR_W-1:0] RANGE_BYTES = ADDR_W'(NUM_WORDS * 4);

  state_e            state;
  logic [MEM_AW-1:0] fill_cnt;
  logic              fill_done;
  logic              init_fall;
  logic              fill_clr;
  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic              gnt;
  logic              rsp_valid;
  rsp_e              rsp_sel;
  logic              err;

  assign offset   = tcdm.add - BASE_ADDR;
  assign in_range = addr_in_range(offset, RANGE_BYTES);
  assign fill_clr = (state == S_RUN) && init_fall;

  l2_bank_init_seq #(
    .NUM_WORDS (NUM_WORDS)
  ) u_init_seq (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .init_n    (init_ni),
    .fill_en   (state == S_INIT),
    .fill_clr  (fill_clr),
    .cnt       (fill_cnt),
    .done      (fill_done),
    .init_fall (init_fall)
  );

  // Grant and SRAM strobes are combinational so an in-range read sees its
  // data exactly one cycle later. They are qualified with rst_ni so every
  // output sits at its idle value for the whole time reset is held.
  always_comb begin
    gnt         = 1'b0;
    busy_o      = 1'b0;
    mem_csn_o   = 1'b1;
    mem_wen_o   = 1'b1;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (rst_ni) begin
      case (state)
        S_INIT: begin
          busy_o     = 1'b1;
          mem_csn_o  = 1'b0;
          mem_wen_o  = 1'b0;
          mem_be_o   = '1;
          mem_addr_o = fill_cnt;
        end
        S_RUN: begin
          gnt = tcdm.req;
          if (tcdm.req && in_range) begin
            mem_csn_o   = 1'b0;
            mem_wen_o   = tcdm.wen;
            mem_addr_o  = offset[MEM_AW+1:2];
            mem_wdata_o = tcdm.wdata;
            mem_be_o    = tcdm.be;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= INIT_ON_RESET ? S_INIT : S_RUN;
      rsp_valid <= 1'b0;
      rsp_sel   <= RSP_ZERO;
      err       <= 1'b0;
    end else begin
      case (state)
        S_INIT:  if (fill_done) state <= S_RUN;
        S_RUN:   if (init_fall) state <= S_INIT;
        default: state <= S_RUN;
      endcase

      // A grant in the cycle init_ni falls still gets its response here.
      rsp_valid <= gnt;
      if (gnt) begin
        if (!tcdm.wen)     rsp_sel <= RSP_ZERO;
        else if (in_range) rsp_sel <= RSP_MEM;
        else               rsp_sel <= RSP_ERR;
      end

      if (gnt && !in_range) begin
        err <= 1'b1;
      end else if (err_clr_i) begin
        err <= 1'b0;
      end
    end
  end

  always_comb begin
    tcdm.r_rdata = '0;
    if (rsp_valid) begin
      case (rsp_sel)
        RSP_MEM:  tcdm.r_rdata = mem_rdata_i;
        RSP_ERR:  tcdm.r_rdata = ERR_DATA;
        default:  tcdm.r_rdata = '0;
      endcase
    end
  end

  assign tcdm.gnt     = gnt;
  assign tcdm.r_valid = rsp_valid;
  assign err_o        = err;

`ifdef L2_BANK_ACC_CNT_EN
  logic [31:0] rd_cnt;
  logic [31:0] wr_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (err_clr_i) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else if (gnt && in_range) begin
      if (tcdm.wen && rd_cnt != '1)  rd_cnt <= rd_cnt + 1'b1;
      if (!tcdm.wen && wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
    end
  end

  assign rd_cnt_o = rd_cnt;
  assign wr_cnt_o = wr_cnt;
`endif

endmodule
